// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the five-stage pipeline controller: stall bus layout,
// instruction address width and controller state encodings.
package pipe_ctrl_pkg;

  localparam int StallW = 6;
  typedef logic [StallW-1:0] stall_bus_t;

  localparam int StallPC  = 0;
  localparam int StallIF  = 1;
  localparam int StallID  = 2;
  localparam int StallEX  = 3;
  localparam int StallMEM = 4;
  localparam int StallWB  = 5;

  localparam int InstAddrW = 32;
  typedef logic [InstAddrW-1:0] inst_addr_t;
  localparam inst_addr_t ZeroWord = '0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Hold every stage from the PC up to and including the requesting stage.
  function automatic stall_bus_t stall_upto(input int stage);
    stall_bus_t m;
    for (int i = 0; i < StallW; i++) m[i] = (i <= stage);
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_req;
  inst_addr_t  excp_pc;
  stall_bus_t  stall;
  logic        flush;
  logic        pc_load;
  inst_addr_t  new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
    input  stall, flush, pc_load, new_pc, stall_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, excp_req, excp_pc,
    output stall, flush, pc_load, new_pc, stall_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_ctrl_satcnt.sv
// Saturating up-counter with synchronous clear; at_limit flags cnt == LIMIT.
module pipe_ctrl_satcnt #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (inc && !at_limit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_limit = (cnt_q == W'(LIMIT));
  assign cnt      = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall priority merge, exception flush and
// PC redirect sequencing, stall watchdog. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN     = 1,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int FcntW = $clog2(FLUSH_LEN + 1);
  localparam int WdW   = $clog2(STALL_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  inst_addr_t       new_pc_q, new_pc_d;
  logic             flush_q, flush_d;
  logic             pc_load_q, pc_load_d;
  logic             timeout_q, timeout_d;

  logic       in_run, any_req, accept_excp;
  stall_bus_t stall_dec, stall_vec;
  logic       wd_inc, wd_clr, wd_at_limit, wd_hit;
  logic [WdW-1:0] wd_cnt;

  always_comb begin
    in_run      = (state_q == ST_RUN);
    any_req     = bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;
    accept_excp = in_run & bus.excp_req;
    if (bus.stallreq_mem)     stall_dec = stall_upto(StallMEM);
    else if (bus.stallreq_ex) stall_dec = stall_upto(StallEX);
    else if (bus.stallreq_id) stall_dec = stall_upto(StallID);
    else                      stall_dec = '0;
    // An accepted exception wins over any stall raised in the same cycle.
    stall_vec = (in_run && !bus.excp_req) ? stall_dec : '0;
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (accept_excp) begin
          state_d  = ST_FLUSH;
          fcnt_d   = FcntW'(FLUSH_LEN - 1);
          new_pc_d = bus.excp_pc;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) state_d = ST_REDIRECT;
        else              fcnt_d  = fcnt_q - 1'b1;
      end
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    flush_d   = (state_d == ST_FLUSH);
    pc_load_d = (state_d == ST_REDIRECT);
  end

  // Watchdog: counts consecutive stalled RUN cycles, flag latches on the
  // edge that completes the STALL_TIMEOUT-th one.
  always_comb begin
    wd_inc    = accept_excp ? 1'b0 : (in_run & any_req);
    wd_clr    = in_run & (~any_req | bus.excp_req);
    wd_hit    = wd_inc & (wd_at_limit | (wd_cnt == WdW'(STALL_TIMEOUT - 1)));
    timeout_d = timeout_q | wd_hit;
  end

  pipe_ctrl_satcnt #(.LIMIT(STALL_TIMEOUT), .W(WdW)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .inc      (wd_inc),
    .clr      (wd_clr),
    .cnt      (wd_cnt),
    .at_limit (wd_at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      fcnt_q    <= '0;
      new_pc_q  <= ZeroWord;
      flush_q   <= 1'b0;
      pc_load_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      new_pc_q  <= new_pc_d;
      flush_q   <= flush_d;
      pc_load_q <= pc_load_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, |stall_vec};
    flush_count_d  = flush_count_q + {31'd0, accept_excp};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`else
  assign bus.stall_cycles = ZeroWord;
  assign bus.flush_count  = ZeroWord;
`endif

  assign bus.stall         = stall_vec;
  assign bus.flush         = flush_q;
  assign bus.pc_load       = pc_load_q;
  assign bus.new_pc        = new_pc_q;
  assign bus.stall_timeout = timeout_q;

endmodule
